// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-bit-opcode core: opcode values and the
// sequencer state type, used by both the PC sequencer and the control decoder.
package cpu_pkg;

   localparam int OPW = 5;

   localparam logic [OPW-1:0] OP_JE    = 5'b00011;
   localparam logic [OPW-1:0] OP_JZ    = 5'b00100;
   localparam logic [OPW-1:0] OP_STORE = 5'b01001;
   localparam logic [OPW-1:0] OP_LOAD  = 5'b01010;
   localparam logic [OPW-1:0] OP_CALL  = 5'b01011;
   localparam logic [OPW-1:0] OP_RET   = 5'b01100;
   localparam logic [OPW-1:0] OP_HALT  = 5'b11111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      LOAD_WAIT,
      HALT
   } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO for CALL/RET. The top entry is visible on dout
// combinationally so a RET can redirect the PC in the same cycle.
module ret_stack #(
   parameter int PCW   = 10,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  logic           pop,
   input  logic [PCW-1:0] din,
   output logic [PCW-1:0] dout,
   output logic           full,
   output logic           empty
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;

   logic [PCW-1:0] r_mem [DEPTH];
   logic [SPW-1:0] r_sp;
   logic [AW-1:0]  w_top;

   assign w_top = r_sp[AW-1:0] - AW'(1);
   assign dout  = r_mem[w_top];
   assign full  = (r_sp == SPW'(DEPTH));
   assign empty = (r_sp == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sp <= '0;
      end else if (push) begin
         r_sp <= r_sp + SPW'(1);
      end else if (pop) begin
         r_sp <= r_sp - SPW'(1);
      end
   end

   // Entry contents need no reset; only the pointer defines what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_sp[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC and return stack, resolves JE/JZ
// against ALU flags, stalls one cycle on LOAD and handles start/halt/fault.
module pc_sequencer #(
   parameter int PCW   = 10,
   parameter int OPW   = 5,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [PCW-1:0] start_addr,
   input  logic [OPW-1:0] opcode,
   input  logic [PCW-1:0] target,
   input  logic           flag_eq,
   input  logic           flag_zero,
   output logic [PCW-1:0] pc,
   output logic           stall,
   output logic           done,
   output logic           fault,
   output logic           busy
);

   import cpu_pkg::*;

   seq_state_t     r_state;
   seq_state_t     w_state_nxt;
   logic [PCW-1:0] r_pc;
   logic [PCW-1:0] w_pc_nxt;
   logic [PCW-1:0] w_pc_inc;
   logic [PCW-1:0] w_stk_dout;
   logic           r_done;
   logic           r_fault;
   logic           w_done_nxt;
   logic           w_fault_nxt;
   logic           w_push;
   logic           w_pop;
   logic           w_clr;
   logic           w_full;
   logic           w_empty;
   logic           w_stk_rst;

   assign w_pc_inc  = r_pc + PCW'(1);
   assign w_stk_rst = reset | w_clr;

   ret_stack #(
      .PCW   (PCW),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .reset (w_stk_rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_pc_inc),
      .dout  (w_stk_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_done  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_done  <= w_done_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_done_nxt  = r_done;
      w_fault_nxt = r_fault;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_pc_nxt    = start_addr;
               w_clr       = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            case (opcode)
               OP_JE:    w_pc_nxt = flag_eq   ? target : w_pc_inc;
               OP_JZ:    w_pc_nxt = flag_zero ? target : w_pc_inc;
               OP_STORE: w_pc_nxt = w_pc_inc;
               OP_CALL: begin
                  if (!w_full) begin
                     w_push   = 1'b1;
                     w_pc_nxt = target;
                  end else begin
                     w_fault_nxt = 1'b1;
                     w_state_nxt = HALT;
                  end
               end
               OP_RET: begin
                  if (!w_empty) begin
                     w_pop    = 1'b1;
                     w_pc_nxt = w_stk_dout;
                  end else begin
                     w_fault_nxt = 1'b1;
                     w_state_nxt = HALT;
                  end
               end
               OP_LOAD:  w_state_nxt = LOAD_WAIT;
               OP_HALT: begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = HALT;
               end
               default:  w_pc_nxt = w_pc_inc;
            endcase
         end
         LOAD_WAIT: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = RUN;
         end
         HALT: begin
            if (start) begin
               w_done_nxt  = 1'b0;
               w_fault_nxt = 1'b0;
               w_pc_nxt    = start_addr;
               w_clr       = 1'b1;
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Stall only in the LOAD issue cycle; LOAD_WAIT is the commit cycle.
   always_comb begin
      stall = (r_state == RUN) && (opcode == OP_LOAD);
      busy  = (r_state == RUN) || (r_state == LOAD_WAIT);
   end

   assign pc    = r_pc;
   assign done  = r_done;
   assign fault = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run checked
// against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

   localparam logic [4:0] T_NOP   = 5'b00000;
   localparam logic [4:0] T_JE    = 5'b00011;
   localparam logic [4:0] T_JZ    = 5'b00100;
   localparam logic [4:0] T_STORE = 5'b01001;
   localparam logic [4:0] T_LOAD  = 5'b01010;
   localparam logic [4:0] T_CALL  = 5'b01011;
   localparam logic [4:0] T_RET   = 5'b01100;
   localparam logic [4:0] T_HALT  = 5'b11111;

   logic       clk;
   logic       reset;
   logic       start;
   logic [9:0] start_addr;
   logic [4:0] opcode;
   logic [9:0] target;
   logic       flag_eq;
   logic       flag_zero;
   logic [9:0] pc;
   logic       stall;
   logic       done;
   logic       fault;
   logic       busy;

   int checks;
   int failures;

   pc_sequencer #(.PCW(10), .OPW(5), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .opcode     (opcode),
      .target     (target),
      .flag_eq    (flag_eq),
      .flag_zero  (flag_zero),
      .pc         (pc),
      .stall      (stall),
      .done       (done),
      .fault      (fault),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [4:0] op, input logic [9:0] tg, input logic fe,
                      input logic fz, input logic st, input logic [9:0] sa);
      opcode = op; target = tg; flag_eq = fe; flag_zero = fz; start = st; start_addr = sa;
   endtask

   // Taken JE used to position the PC while in RUN.
   task automatic goto_pc(input logic [9:0] a);
      drv(T_JE, a, 1'b1, 1'b0, 1'b0, 10'h0);
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (pc !== 10'h000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 10'h000); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
   endtask

   task automatic test_idle();
      drv(T_LOAD, 10'h2AA, 1'b1, 1'b1, 1'b0, 10'h155);
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", stall); end
      tick();
      drv(T_CALL, 10'h2AA, 1'b1, 1'b1, 1'b0, 10'h155);
      tick();
      checks++; if (pc !== 10'h000) begin failures++; $display("FAIL idle_pc got=%h exp=%h", pc, 10'h000); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_sequential();
      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b1, 10'h010);
      tick();
      start = 1'b0;
      #1;
      checks++; if (pc !== 10'h010) begin failures++; $display("FAIL seq_pc0 got=%h exp=%h", pc, 10'h010); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL seq_busy got=%b exp=1", busy); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL seq_stall got=%b exp=0", stall); end
      tick();
      checks++; if (pc !== 10'h011) begin failures++; $display("FAIL seq_pc1 got=%h exp=%h", pc, 10'h011); end
      tick();
      checks++; if (pc !== 10'h012) begin failures++; $display("FAIL seq_pc2 got=%h exp=%h", pc, 10'h012); end
      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b1, 10'h123);
      tick();
      start = 1'b0;
      checks++; if (pc !== 10'h013) begin failures++; $display("FAIL seq_start_busy got=%h exp=%h", pc, 10'h013); end
   endtask

   task automatic test_branch();
      goto_pc(10'h020);
      checks++; if (pc !== 10'h020) begin failures++; $display("FAIL br_goto got=%h exp=%h", pc, 10'h020); end
      drv(T_JE, 10'h050, 1'b1, 1'b0, 1'b0, 10'h0);
      tick();
      checks++; if (pc !== 10'h050) begin failures++; $display("FAIL br_je_taken got=%h exp=%h", pc, 10'h050); end
      goto_pc(10'h020);
      drv(T_JE, 10'h050, 1'b0, 1'b1, 1'b0, 10'h0);
      tick();
      checks++; if (pc !== 10'h021) begin failures++; $display("FAIL br_je_not got=%h exp=%h", pc, 10'h021); end
      drv(T_JZ, 10'h100, 1'b0, 1'b1, 1'b0, 10'h0);
      tick();
      checks++; if (pc !== 10'h100) begin failures++; $display("FAIL br_jz_taken got=%h exp=%h", pc, 10'h100); end
      drv(T_JZ, 10'h200, 1'b1, 1'b0, 1'b0, 10'h0);
      tick();
      checks++; if (pc !== 10'h101) begin failures++; $display("FAIL br_jz_not got=%h exp=%h", pc, 10'h101); end
   endtask

   task automatic test_load();
      goto_pc(10'h030);
      drv(T_LOAD, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0);
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ld_stall1 got=%b exp=1", stall); end
      checks++; if (pc !== 10'h030) begin failures++; $display("FAIL ld_pc_hold got=%h exp=%h", pc, 10'h030); end
      tick();
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ld_stall_wait got=%b exp=0", stall); end
      checks++; if (pc !== 10'h030) begin failures++; $display("FAIL ld_pc_wait got=%h exp=%h", pc, 10'h030); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ld_busy_wait got=%b exp=1", busy); end
      tick();
      opcode = T_NOP;
      checks++; if (pc !== 10'h031) begin failures++; $display("FAIL ld_pc_next got=%h exp=%h", pc, 10'h031); end
   endtask

   task automatic test_call_ret();
      goto_pc(10'h040);
      drv(T_CALL, 10'h200, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (pc !== 10'h200) begin failures++; $display("FAIL cr_call1 got=%h exp=%h", pc, 10'h200); end
      drv(T_CALL, 10'h300, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (pc !== 10'h300) begin failures++; $display("FAIL cr_call2 got=%h exp=%h", pc, 10'h300); end
      drv(T_RET, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (pc !== 10'h201) begin failures++; $display("FAIL cr_ret1 got=%h exp=%h", pc, 10'h201); end
      tick();
      checks++; if (pc !== 10'h041) begin failures++; $display("FAIL cr_ret2 got=%h exp=%h", pc, 10'h041); end
      goto_pc(10'h040);
      drv(T_CALL, 10'h200, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      drv(T_RET, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (pc !== 10'h041) begin failures++; $display("FAIL cr_back2back got=%h exp=%h", pc, 10'h041); end
      goto_pc(10'h060);
      for (int i = 0; i < 4; i++) begin
         drv(T_CALL, 10'h100 + 10'(i * 16), 1'b0, 1'b0, 1'b0, 10'h0);
         tick();
      end
      checks++; if (pc !== 10'h130) begin failures++; $display("FAIL cr_fill_pc got=%h exp=%h", pc, 10'h130); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL cr_fill_fault got=%b exp=0", fault); end
      drv(T_CALL, 10'h140, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL cr_ovf_fault got=%b exp=1", fault); end
      checks++; if (pc !== 10'h130) begin failures++; $display("FAIL cr_ovf_pc got=%h exp=%h", pc, 10'h130); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cr_ovf_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL cr_ovf_done got=%b exp=0", done); end
      tick();
      checks++; if (pc !== 10'h130) begin failures++; $display("FAIL cr_halt_frozen got=%h exp=%h", pc, 10'h130); end
      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b1, 10'h005); tick();
      start = 1'b0;
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL cr_restart_fault got=%b exp=0", fault); end
      checks++; if (pc !== 10'h005) begin failures++; $display("FAIL cr_restart_pc got=%h exp=%h", pc, 10'h005); end
      drv(T_RET, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL cr_unf_fault got=%b exp=1", fault); end
      checks++; if (pc !== 10'h005) begin failures++; $display("FAIL cr_unf_pc got=%h exp=%h", pc, 10'h005); end
   endtask

   task automatic test_wrap_halt();
      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b1, 10'h3FE); tick();
      start = 1'b0;
      tick();
      checks++; if (pc !== 10'h3FF) begin failures++; $display("FAIL wr_pc3ff got=%h exp=%h", pc, 10'h3FF); end
      tick();
      checks++; if (pc !== 10'h000) begin failures++; $display("FAIL wr_wrap got=%h exp=%h", pc, 10'h000); end
      goto_pc(10'h3FF);
      drv(T_CALL, 10'h010, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      drv(T_RET, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (pc !== 10'h000) begin failures++; $display("FAIL wr_ret_wrap got=%h exp=%h", pc, 10'h000); end
      drv(T_HALT, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL wr_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_halt_busy got=%b exp=0", busy); end
      tick();
      checks++; if (pc !== 10'h000) begin failures++; $display("FAIL wr_halt_pc got=%h exp=%h", pc, 10'h000); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL wr_done_held got=%b exp=1", done); end
      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b1, 10'h005); tick();
      start = 1'b0;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL wr_restart_done got=%b exp=0", done); end
      checks++; if (pc !== 10'h005) begin failures++; $display("FAIL wr_restart_pc got=%h exp=%h", pc, 10'h005); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_restart_busy got=%b exp=1", busy); end
   endtask

   task automatic test_reset_loadwait();
      drv(T_CALL, 10'h080, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      drv(T_LOAD, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rl_wait_busy got=%b exp=1", busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (pc !== 10'h000) begin failures++; $display("FAIL rl_pc got=%h exp=%h", pc, 10'h000); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rl_busy got=%b exp=0", busy); end
      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b1, 10'h050); tick();
      start = 1'b0;
      checks++; if (pc !== 10'h050) begin failures++; $display("FAIL rl_start_pc got=%h exp=%h", pc, 10'h050); end
      drv(T_RET, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0); tick();
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL rl_stack_empty got=%b exp=1", fault); end
   endtask

   // Behavioural model: state as a small integer, return stack as a queue.
   task automatic test_random();
      int         m_st;     // 0 idle, 1 run, 2 load wait, 3 halted
      logic [9:0] m_pc;
      logic       m_done;
      logic       m_fault;
      logic [9:0] stk[$];
      int         r;
      logic       e_stall;
      logic       e_busy;

      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_st = 0; m_pc = '0; m_done = 1'b0; m_fault = 1'b0; stk.delete();

      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 15);
         case (r)
            0, 1, 2, 3, 4: opcode = 5'($urandom_range(0, 31));
            5, 6:          opcode = T_JE;
            7, 8:          opcode = T_JZ;
            9:             opcode = T_LOAD;
            10, 11:        opcode = T_CALL;
            12, 13:        opcode = T_RET;
            14:            opcode = T_STORE;
            default:       opcode = T_HALT;
         endcase
         target     = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom());
         start_addr = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom());
         flag_eq    = 1'($urandom());
         flag_zero  = 1'($urandom());
         start      = ($urandom_range(0, 3) == 0);
         reset      = ($urandom_range(0, 199) == 0);
         #1;
         e_stall = (m_st == 1) && (opcode == T_LOAD);
         e_busy  = (m_st == 1) || (m_st == 2);
         checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); end
         checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, e_busy); end
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, e_stall); end
         checks++; if (done !== m_done) begin failures++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, done, m_done); end
         checks++; if (fault !== m_fault) begin failures++; $display("FAIL rnd_fault cyc=%0d got=%b exp=%b", i, fault, m_fault); end

         if (reset) begin
            m_st = 0; m_pc = '0; m_done = 1'b0; m_fault = 1'b0; stk.delete();
         end else begin
            case (m_st)
               0: if (start) begin m_pc = start_addr; stk.delete(); m_st = 1; end
               1: begin
                  if (opcode == T_JE) m_pc = flag_eq ? target : m_pc + 10'd1;
                  else if (opcode == T_JZ) m_pc = flag_zero ? target : m_pc + 10'd1;
                  else if (opcode == T_CALL) begin
                     if (stk.size() < 4) begin stk.push_back(m_pc + 10'd1); m_pc = target; end
                     else begin m_fault = 1'b1; m_st = 3; end
                  end else if (opcode == T_RET) begin
                     if (stk.size() > 0) m_pc = stk.pop_back();
                     else begin m_fault = 1'b1; m_st = 3; end
                  end else if (opcode == T_LOAD) m_st = 2;
                  else if (opcode == T_HALT) begin m_done = 1'b1; m_st = 3; end
                  else m_pc = m_pc + 10'd1;
               end
               2: begin m_pc = m_pc + 10'd1; m_st = 1; end
               default: if (start) begin
                  m_done = 1'b0; m_fault = 1'b0; m_pc = start_addr; stk.delete(); m_st = 1;
               end
            endcase
         end
         tick();
      end
      reset = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      drv(T_NOP, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0);
      #2;
      test_reset();
      test_idle();
      test_sequential();
      test_branch();
      test_load();
      test_call_ret();
      test_wrap_halt();
      test_reset_loadwait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
